amba_axi4_lite_slave_regfile: RTL

//  AXI4-Lite responder (slave) backed by a flat register file of NUM_REGS words.

---
 rtl/amba_axi4_lite_slave_regfile.sv | 305 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/amba_axi4_lite_slave_regfile.sv
// AXI4-Lite responder backed by a flat register file of NUM_REGS words.
// The write path (AW/W -> B) and the read path (AR -> R) are independent
// and run concurrently. Every output is driven straight from a flop, so no
// input reaches any output combinationally. The next-state logic decides
// what the READY/VALID flops will present in the following cycle.
// Addresses at or beyond NUM_REGS words decode to DECERR. A DECERR write
// leaves the file untouched, and a DECERR read returns zero data.

module amba_axi4_lite_slave_regfile #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 64,
   parameter int NUM_REGS      = 16
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   // write address channel
   input  logic                      AWVALID,
   output logic                      AWREADY,
   input  logic [ADDRESS_WIDTH-1:0]  AWADDR,
   input  logic [2:0]                AWPROT,
   // write data channel
   input  logic                      WVALID,
   output logic                      WREADY,
   input  logic [DATA_WIDTH-1:0]     WDATA,
   input  logic [DATA_WIDTH/8-1:0]   WSTRB,
   // write response channel
   output logic                      BVALID,
   input  logic                      BREADY,
   output logic [1:0]                BRESP,
   // read address channel
   input  logic                      ARVALID,
   output logic                      ARREADY,
   input  logic [ADDRESS_WIDTH-1:0]  ARADDR,
   input  logic [2:0]                ARPROT,
   // read data channel
   output logic                      RVALID,
   input  logic                      RREADY,
   output logic [DATA_WIDTH-1:0]     RDATA,
   output logic [1:0]                RRESP
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int OFS        = $clog2(STRB_WIDTH);
   localparam int IDX_W      = ADDRESS_WIDTH - OFS;

   localparam logic [IDX_W-1:0] NUM_REGS_IDX = IDX_W'(NUM_REGS);
   localparam logic [1:0]       RESP_OKAY    = 2'b00;
   localparam logic [1:0]       RESP_DECERR  = 2'b11;

   typedef enum logic [1:0] {
      WR_IDLE    = 2'b00,
      WR_HAVE_AW = 2'b01,
      WR_HAVE_W  = 2'b10,
      WR_RESP    = 2'b11
   } wr_state_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_RESP = 1'b1
   } rd_state_t;

   // True when a word index maps onto an implemented register.
   function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
      return (idx < NUM_REGS_IDX);
   endfunction

   // Byte-lane merge: lanes with a set strobe take the new byte, others keep the old one.
   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [STRB_WIDTH-1:0] strb
   );
      logic [DATA_WIDTH-1:0] merged;
      merged = old_word;
      for (int i = 0; i < STRB_WIDTH; i++) begin
         if (strb[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            merged[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

   // register file
   logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

   // write path state
   wr_state_t             wr_state_r;
   wr_state_t             wr_next_s;
   logic [IDX_W-1:0]      aw_idx_r;
   logic [DATA_WIDTH-1:0] w_data_r;
   logic [STRB_WIDTH-1:0] w_strb_r;
   logic                  awready_r;
   logic                  wready_r;
   logic                  bvalid_r;
   logic [1:0]            bresp_r;

   logic                  aw_hs_s;
   logic                  w_hs_s;
   logic [IDX_W-1:0]      awaddr_idx_s;
   logic                  latch_aw_s;
   logic                  latch_w_s;
   logic                  commit_s;
   logic [IDX_W-1:0]      commit_idx_s;
   logic [DATA_WIDTH-1:0] commit_data_s;
   logic [STRB_WIDTH-1:0] commit_strb_s;

   // read path state
   rd_state_t             rd_state_r;
   rd_state_t             rd_next_s;
   logic                  arready_r;
   logic                  rvalid_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic [1:0]            rresp_r;

   logic                  ar_hs_s;
   logic [IDX_W-1:0]      araddr_idx_s;
   logic [DATA_WIDTH-1:0] rd_word_s;

   // Protection bits and sub-word address bits carry no meaning here.
   logic                  unused_s;
   assign unused_s = ^{AWPROT, ARPROT, AWADDR[OFS-1:0], ARADDR[OFS-1:0]};

   assign awaddr_idx_s = AWADDR[ADDRESS_WIDTH-1:OFS];
   assign araddr_idx_s = ARADDR[ADDRESS_WIDTH-1:OFS];

   assign aw_hs_s = AWVALID & awready_r;
   assign w_hs_s  = WVALID  & wready_r;
   assign ar_hs_s = ARVALID & arready_r;

   assign AWREADY = awready_r;
   assign WREADY  = wready_r;
   assign BVALID  = bvalid_r;
   assign BRESP   = bresp_r;
   assign ARREADY = arready_r;
   assign RVALID  = rvalid_r;
   assign RDATA   = rdata_r;
   assign RRESP   = rresp_r;

   // Write FSM next state, capture strobes and the commit request
   always_comb begin
      wr_next_s     = wr_state_r;
      latch_aw_s    = 1'b0;
      latch_w_s     = 1'b0;
      commit_s      = 1'b0;
      commit_idx_s  = aw_idx_r;
      commit_data_s = w_data_r;
      commit_strb_s = w_strb_r;
      case (wr_state_r)
         WR_IDLE: begin
            if (aw_hs_s && w_hs_s) begin
               wr_next_s     = WR_RESP;
               commit_s      = 1'b1;
               commit_idx_s  = awaddr_idx_s;
               commit_data_s = WDATA;
               commit_strb_s = WSTRB;
            end else if (aw_hs_s) begin
               wr_next_s  = WR_HAVE_AW;
               latch_aw_s = 1'b1;
            end else if (w_hs_s) begin
               wr_next_s = WR_HAVE_W;
               latch_w_s = 1'b1;
            end else begin
               wr_next_s = WR_IDLE;
            end
         end
         WR_HAVE_AW: begin
            if (w_hs_s) begin
               wr_next_s     = WR_RESP;
               commit_s      = 1'b1;
               commit_data_s = WDATA;
               commit_strb_s = WSTRB;
            end else begin
               wr_next_s = WR_HAVE_AW;
            end
         end
         WR_HAVE_W: begin
            if (aw_hs_s) begin
               wr_next_s    = WR_RESP;
               commit_s     = 1'b1;
               commit_idx_s = awaddr_idx_s;
            end else begin
               wr_next_s = WR_HAVE_W;
            end
         end
         WR_RESP: begin
            if (bvalid_r && BREADY) begin
               wr_next_s = WR_IDLE;
            end else begin
               wr_next_s = WR_RESP;
            end
         end
         default: begin
            wr_next_s = WR_IDLE;
         end
      endcase
   end

   // Write FSM state, half-transaction capture and registered AW/W/B outputs
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         wr_state_r <= WR_IDLE;
         aw_idx_r   <= {IDX_W{1'b0}};
         w_data_r   <= {DATA_WIDTH{1'b0}};
         w_strb_r   <= {STRB_WIDTH{1'b0}};
         awready_r  <= 1'b0;
         wready_r   <= 1'b0;
         bvalid_r   <= 1'b0;
         bresp_r    <= RESP_OKAY;
      end else begin
         wr_state_r <= wr_next_s;
         if (latch_aw_s) begin
            aw_idx_r <= awaddr_idx_s;
         end
         if (latch_w_s) begin
            w_data_r <= WDATA;
            w_strb_r <= WSTRB;
         end
         awready_r <= (wr_next_s == WR_IDLE) || (wr_next_s == WR_HAVE_W);
         wready_r  <= (wr_next_s == WR_IDLE) || (wr_next_s == WR_HAVE_AW);
         bvalid_r  <= (wr_next_s == WR_RESP);
         // BRESP only changes on the commit edge, so it holds while BVALID waits.
         if (commit_s) begin
            bresp_r <= idx_in_range(commit_idx_s) ? RESP_OKAY : RESP_DECERR;
         end
      end
   end

   // Register file: clear on reset, byte-merge the committed write into the addressed word
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (commit_s && idx_in_range(commit_idx_s)) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_idx_s == IDX_W'(i)) begin
               regs_r[i] <= merge_bytes(regs_r[i], commit_data_s, commit_strb_s);
            end
         end
      end
   end

   // Read word select from the current (pre-commit) register contents
   always_comb begin
      rd_word_s = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
         if (araddr_idx_s == IDX_W'(i)) begin
            rd_word_s = regs_r[i];
         end else begin
            rd_word_s = rd_word_s;
         end
      end
   end

   // Read FSM next state
   always_comb begin
      rd_next_s = rd_state_r;
      case (rd_state_r)
         RD_IDLE: begin
            if (ar_hs_s) begin
               rd_next_s = RD_RESP;
            end else begin
               rd_next_s = RD_IDLE;
            end
         end
         RD_RESP: begin
            if (rvalid_r && RREADY) begin
               rd_next_s = RD_IDLE;
            end else begin
               rd_next_s = RD_RESP;
            end
         end
         default: begin
            rd_next_s = RD_IDLE;
         end
      endcase
   end

   // Read FSM state, registered AR/R outputs and read-data capture at the AR handshake
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         rd_state_r <= RD_IDLE;
         arready_r  <= 1'b0;
         rvalid_r   <= 1'b0;
         rdata_r    <= {DATA_WIDTH{1'b0}};
         rresp_r    <= RESP_OKAY;
      end else begin
         rd_state_r <= rd_next_s;
         arready_r  <= (rd_next_s == RD_IDLE);
         rvalid_r   <= (rd_next_s == RD_RESP);
         if (ar_hs_s) begin
            if (idx_in_range(araddr_idx_s)) begin
               rdata_r <= rd_word_s;
               rresp_r <= RESP_OKAY;
            end else begin
               rdata_r <= {DATA_WIDTH{1'b0}};
               rresp_r <= RESP_DECERR;
            end
         end
      end
   end

endmodule
